// File: rtl/decode_control_pipe_if.sv
// rtl/decode_control_pipe_if.sv - ID-side and EX-side signal bundle for the decode control pipe
interface decode_control_pipe_if;
  // ID side
  logic       id_valid;
  logic       id_ready;
  logic [6:0] opcode;
  logic [6:0] fun7_5_id;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rs3;
  logic       flush;
  // EX side
  logic       ex_valid;
  logic       ex_ready;
  logic       ex_ctrl_reg_write;
  logic       ex_ctrl_fp_reg_write;
  logic       ex_ctrl_mem_write;
  logic       ex_ctrl_mem_to_reg;
  logic       ex_ctrl_branch;
  logic       ex_ctrl_jump;
  logic       ex_ctrl_jal;
  logic       ex_ctrl_lui;
  logic       ex_ctrl_auipc;
  logic       ex_ctrl_alu_src;
  logic       ex_ctrl_r_type;
  logic       ex_ctrl_rdata1_fp;
  logic       ex_ctrl_rdata2_fp;
  logic       ex_ctrl_illegal;
  logic       ex_ctrl_fp_long;
  logic [2:0] ex_alu_op;
  // scoreboard status
  logic       fp_busy;
  logic [4:0] fp_busy_rd;

  // driver of instructions and EX acceptance
  modport master (
    output id_valid, opcode, fun7_5_id, rd, rs1, rs2, rs3, flush, ex_ready,
    input  id_ready, ex_valid,
    input  ex_ctrl_reg_write, ex_ctrl_fp_reg_write, ex_ctrl_mem_write, ex_ctrl_mem_to_reg,
    input  ex_ctrl_branch, ex_ctrl_jump, ex_ctrl_jal, ex_ctrl_lui, ex_ctrl_auipc,
    input  ex_ctrl_alu_src, ex_ctrl_r_type, ex_ctrl_rdata1_fp, ex_ctrl_rdata2_fp,
    input  ex_ctrl_illegal, ex_ctrl_fp_long, ex_alu_op, fp_busy, fp_busy_rd
  );

  // the decode control pipe itself
  modport slave (
    input  id_valid, opcode, fun7_5_id, rd, rs1, rs2, rs3, flush, ex_ready,
    output id_ready, ex_valid,
    output ex_ctrl_reg_write, ex_ctrl_fp_reg_write, ex_ctrl_mem_write, ex_ctrl_mem_to_reg,
    output ex_ctrl_branch, ex_ctrl_jump, ex_ctrl_jal, ex_ctrl_lui, ex_ctrl_auipc,
    output ex_ctrl_alu_src, ex_ctrl_r_type, ex_ctrl_rdata1_fp, ex_ctrl_rdata2_fp,
    output ex_ctrl_illegal, ex_ctrl_fp_long, ex_alu_op, fp_busy, fp_busy_rd
  );
endinterface

// File: rtl/decode_control_pipe.sv
// rtl/decode_control_pipe.sv - RV32IMF decode control, ID/EX register and long-FP-op scoreboard
module decode_control_pipe #(
  parameter int FDIV_LAT  = 10,
  parameter int FSQRT_LAT = 12,
  parameter int CNT_W     = 5
) (
  input logic                  clk,
  input logic                  reset,
  decode_control_pipe_if.slave bus
);

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_FLW     = 7'b0000111;
  localparam logic [6:0] OP_I       = 7'b0010011;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_S       = 7'b0100011;
  localparam logic [6:0] OP_FSW     = 7'b0100111;
  localparam logic [6:0] OP_R       = 7'b0110011;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_FMADD   = 7'b1000011;
  localparam logic [6:0] OP_FMSUB   = 7'b1000111;
  localparam logic [6:0] OP_FNMSUB  = 7'b1001011;
  localparam logic [6:0] OP_FNMADD  = 7'b1001111;
  localparam logic [6:0] OP_RFLOAT  = 7'b1010011;
  localparam logic [6:0] OP_B       = 7'b1100011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;

  localparam logic [6:0] F7_FDIV    = 7'b0001100;
  localparam logic [6:0] F7_FSQRT   = 7'b0101100;

  typedef struct packed {
    logic       reg_write;
    logic       fp_reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       jal;
    logic       lui;
    logic       auipc;
    logic       alu_src;
    logic       r_type;
    logic       rdata1_fp;
    logic       rdata2_fp;
    logic       illegal;
    logic       fp_long;
    logic [2:0] alu_op;
  } ctrl_t;

  ctrl_t            dec;
  ctrl_t            ex_q;
  logic             ex_valid_q;
  logic             is_r4;
  logic             fp_to_int;
  logic             int_src;
  logic             hazard;
  logic             transfer;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       busy_rd_q;
  logic             fp_busy;

  // FP ops whose result goes to the integer file (compare/class/move-to-int/convert-to-int)
  assign fp_to_int = (bus.fun7_5_id == 7'b1100000) || (bus.fun7_5_id == 7'b1110000) ||
                     (bus.fun7_5_id == 7'b1010000);
  // FP ops whose rs1 comes from the integer file (convert-from-int/move-from-int)
  assign int_src   = (bus.fun7_5_id == 7'b1101000) || (bus.fun7_5_id == 7'b1111000);

  // opcode/funct7 to control bundle; unknown opcodes leave everything clear except illegal
  always_comb begin
    dec   = '0;
    is_r4 = 1'b0;
    if (bus.opcode[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      unique case (bus.opcode)
        OP_LOAD: begin
          dec.reg_write  = 1'b1;
          dec.mem_to_reg = 1'b1;
          dec.alu_src    = 1'b1;
        end
        OP_FLW: begin
          dec.fp_reg_write = 1'b1;
          dec.mem_to_reg   = 1'b1;
          dec.alu_src      = 1'b1;
          dec.alu_op       = 3'b110;
        end
        OP_I: begin
          dec.reg_write = 1'b1;
          dec.alu_src   = 1'b1;
          dec.alu_op    = 3'b001;
        end
        OP_AUIPC: begin
          dec.reg_write = 1'b1;
          dec.alu_src   = 1'b1;
          dec.auipc     = 1'b1;
        end
        OP_S: begin
          dec.mem_write = 1'b1;
          dec.alu_src   = 1'b1;
        end
        OP_FSW: begin
          dec.mem_write = 1'b1;
          dec.alu_src   = 1'b1;
          dec.rdata2_fp = 1'b1;
          dec.alu_op    = 3'b111;
        end
        OP_R: begin
          dec.reg_write = 1'b1;
          dec.r_type    = 1'b1;
          dec.alu_op    = 3'b011;
        end
        OP_LUI: begin
          dec.reg_write = 1'b1;
          dec.alu_src   = 1'b1;
          dec.lui       = 1'b1;
        end
        OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: begin
          is_r4            = 1'b1;
          dec.fp_reg_write = 1'b1;
          dec.r_type       = 1'b1;
          dec.rdata1_fp    = 1'b1;
          dec.rdata2_fp    = 1'b1;
          dec.alu_op       = 3'b101;
        end
        OP_RFLOAT: begin
          dec.reg_write    = fp_to_int;
          dec.fp_reg_write = ~fp_to_int;
          dec.r_type       = 1'b1;
          dec.rdata1_fp    = ~int_src;
          dec.rdata2_fp    = 1'b1;
          dec.fp_long      = (bus.fun7_5_id == F7_FDIV) || (bus.fun7_5_id == F7_FSQRT);
          dec.alu_op       = 3'b100;
        end
        OP_B: begin
          dec.branch = 1'b1;
          dec.alu_op = 3'b010;
        end
        OP_JALR: begin
          dec.reg_write = 1'b1;
          dec.jump      = 1'b1;
          dec.alu_src   = 1'b1;
        end
        OP_JAL: begin
          dec.reg_write = 1'b1;
          dec.jump      = 1'b1;
          dec.jal       = 1'b1;
          dec.alu_src   = 1'b1;
        end
        default: dec.illegal = 1'b1;
      endcase
    end
  end

  assign fp_busy = (cnt_q != '0);

  // stall when the FPU is busy and ID would reuse it, read its result, or overwrite its target
  always_comb begin
    hazard = 1'b0;
    if (fp_busy) begin
      hazard = dec.fp_long ||
               (dec.rdata1_fp    && (bus.rs1 == busy_rd_q)) ||
               (dec.rdata2_fp    && (bus.rs2 == busy_rd_q)) ||
               (is_r4            && (bus.rs3 == busy_rd_q)) ||
               (dec.fp_reg_write && (bus.rd  == busy_rd_q));
    end
  end

  assign bus.id_ready = (~ex_valid_q | bus.ex_ready) & ~hazard;
  // a redirect kills the instruction in ID as well, so nothing is handed over under flush
  assign transfer     = bus.id_valid & bus.id_ready & ~bus.flush;

  // ID/EX control register: load on transfer, drain on EX acceptance, otherwise hold
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else if (bus.flush) begin
      ex_valid_q <= 1'b0;
    end else if (transfer) begin
      ex_valid_q <= 1'b1;
      ex_q       <= dec;
    end else if (bus.ex_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  // scoreboard for the one outstanding long FP op; flush leaves it alone since the FPU already has it
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      busy_rd_q <= '0;
    end else if (transfer && dec.fp_long) begin
      cnt_q     <= (bus.fun7_5_id == F7_FDIV) ? CNT_W'(FDIV_LAT) : CNT_W'(FSQRT_LAT);
      busy_rd_q <= bus.rd;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign bus.ex_valid             = ex_valid_q;
  assign bus.ex_ctrl_reg_write    = ex_q.reg_write;
  assign bus.ex_ctrl_fp_reg_write = ex_q.fp_reg_write;
  assign bus.ex_ctrl_mem_write    = ex_q.mem_write;
  assign bus.ex_ctrl_mem_to_reg   = ex_q.mem_to_reg;
  assign bus.ex_ctrl_branch       = ex_q.branch;
  assign bus.ex_ctrl_jump         = ex_q.jump;
  assign bus.ex_ctrl_jal          = ex_q.jal;
  assign bus.ex_ctrl_lui          = ex_q.lui;
  assign bus.ex_ctrl_auipc        = ex_q.auipc;
  assign bus.ex_ctrl_alu_src      = ex_q.alu_src;
  assign bus.ex_ctrl_r_type       = ex_q.r_type;
  assign bus.ex_ctrl_rdata1_fp    = ex_q.rdata1_fp;
  assign bus.ex_ctrl_rdata2_fp    = ex_q.rdata2_fp;
  assign bus.ex_ctrl_illegal      = ex_q.illegal;
  assign bus.ex_ctrl_fp_long      = ex_q.fp_long;
  assign bus.ex_alu_op            = ex_q.alu_op;
  assign bus.fp_busy              = fp_busy;
  assign bus.fp_busy_rd           = busy_rd_q;

endmodule
